// File: rtl/add_pkg.sv
// Shared constants for the pipelined adder/subtractor: operation encoding and
// default geometry.
package add_pkg;
    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;
    localparam int   DEF_WIDTH  = 16;
    localparam int   DEF_STAGES = 4;
endpackage

// File: rtl/add_chunk.sv
// Combinational CW-bit ripple slice: {co, s} = a + b + ci.
module add_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks of CW bits.
// Optional flag logic (ovf, zero) is built only with PIPE_ADD_SUB_FLAGS_EN defined.
module pipe_add_sub
    import add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = WIDTH / STAGES;

    // Single global advance: every stage moves together or the whole pipe holds.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Stage k sees only the operand bits not yet consumed (width IW) and
        // accumulates finished sum bits below its own chunk in dn.
        localparam int IW = WIDTH - k * CW;

        logic [IW-1:0]       in_a;
        logic [IW-1:0]       in_b;
        logic                in_c;
        logic                in_v;
        logic [CW-1:0]       ch_s;
        logic                ch_c;
        logic [(k+1)*CW-1:0] dn;

        if (k == 0) begin : g_src
            assign in_a = a;
            assign in_b = (sub == OP_SUB) ? ~b : b;
            assign in_c = (sub == OP_SUB) ? 1'b1 : cin;
            assign in_v = in_valid;
            assign dn   = ch_s;
        end else begin : g_src
            assign in_a = g_stg[k-1].g_nxt.a_p;
            assign in_b = g_stg[k-1].g_nxt.b_p;
            assign in_c = g_stg[k-1].g_nxt.c_p;
            assign in_v = g_stg[k-1].g_nxt.vld_p;
            assign dn   = {ch_s, g_stg[k-1].g_nxt.s_p};
        end

        add_chunk #(.CW(CW)) u_chunk (
            .a  (in_a[CW-1:0]),
            .b  (in_b[CW-1:0]),
            .ci (in_c),
            .s  (ch_s),
            .co (ch_c)
        );

        if (k < STAGES - 1) begin : g_nxt
            // ---- stage k -> k+1 boundary ----
            logic [IW-CW-1:0]    a_p;
            logic [IW-CW-1:0]    b_p;
            logic [(k+1)*CW-1:0] s_p;
            logic                c_p;
            logic                vld_p;

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_p <= in_a[IW-1:CW];
                    b_p <= in_b[IW-1:CW];
                    s_p <= dn;
                    c_p <= ch_c;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= 1'b0;
                end else if (adv) begin
                    vld_p <= in_v;
                end
            end
        end else begin : g_out
            // ---- final stage -> output register boundary ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                end else if (adv) begin
                    out_valid <= in_v;
                    sum       <= dn;
                    cout      <= ch_c;
                end
            end

`ifdef PIPE_ADD_SUB_FLAGS_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            logic msb_ci;
            assign msb_ci = ch_s[CW-1] ^ in_a[CW-1] ^ in_b[CW-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (adv) begin
                    ovf  <= msb_ci ^ ch_c;
                    zero <= (dn == '0);
                end
            end
`endif
        end
    end

`ifndef PIPE_ADD_SUB_FLAGS_EN
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif
endmodule
